pattern_source_64: RTL and testbench

Test-pattern source for the read-throughput test; the upstream mirror of the write test's checker. It generates 64-bit words from a host-selected pattern and writes them into the 64→32 read FIFO that drains into the host pipe-out endpoint. It honours the FIFO full flag and counts the words it delivers. Its generator sequence is bit-identical to the checker's, so the host can validate read data with the same software model.

---
 rtl/pattern_source_64_pkg.sv | 33 +++
 rtl/pattern_source_64_step.sv | 41 ++++
 rtl/pattern_source_64.sv | 95 +++++++++
 tb/tb_pattern_source_64.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_source_64_pkg.sv
// Shared definitions for the read-test pattern source and the write-test checker.
// Pattern codes, FSM encoding, LFSR taps and generator seeds live here.
package pattern_source_64_pkg;

    typedef enum logic [1:0] {
        PAT_COUNT = 2'd0,
        PAT_WALK1 = 2'd1,
        PAT_LFSR  = 2'd2,
        PAT_ALT   = 2'd3
    } pat_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int LFSR_TAP_A = 63;
    localparam int LFSR_TAP_B = 62;
    localparam int LFSR_TAP_C = 60;
    localparam int LFSR_TAP_D = 59;

    localparam logic [63:0] COUNT_SEED = 64'h0;
    localparam logic [63:0] WALK1_SEED = 64'h1;
    localparam logic [63:0] ALT_SEED   = 64'hAAAA_AAAA_AAAA_AAAA;

    localparam logic [31:0] WORDS_MAX = 32'hFFFF_FFFF;

    function automatic logic lfsr_fb(input logic [63:0] w);
        return w[LFSR_TAP_A] ^ w[LFSR_TAP_B] ^ w[LFSR_TAP_C] ^ w[LFSR_TAP_D];
    endfunction

endpackage

// File: rtl/pattern_source_64_step.sv
// Combinational generator step shared with the checker.
// Gives the next word of the selected pattern and that pattern's seed.
module pattern_step64
    import pattern_source_64_pkg::*;
#(
    parameter logic [63:0] SEED_LFSR = 64'h0123_4567_89AB_CDEF
) (
    input  pat_e        pat,
    input  logic [63:0] cur,
    output logic [63:0] nxt,
    output logic [63:0] seed
);

    always_comb begin
        nxt  = cur;
        seed = COUNT_SEED;
        unique case (1'b1)
            (pat == PAT_COUNT): begin
                nxt  = cur + 64'd1;
                seed = COUNT_SEED;
            end
            (pat == PAT_WALK1): begin
                nxt  = {cur[62:0], cur[63]};
                seed = WALK1_SEED;
            end
            (pat == PAT_LFSR): begin
                nxt  = {cur[62:0], lfsr_fb(cur)};
                seed = SEED_LFSR;
            end
            (pat == PAT_ALT): begin
                nxt  = ~cur;
                seed = ALT_SEED;
            end
            default: begin
                nxt  = cur;
                seed = COUNT_SEED;
            end
        endcase
    end

endmodule

// File: rtl/pattern_source_64.sv
// Pattern source feeding the 64->32 read FIFO; counts delivered words.
// Define PATGEN_SWAP_HALVES_EN to emit the low 32-bit half first to the host.
module pattern_source_64
    import pattern_source_64_pkg::*;
#(
    parameter logic [63:0] SEED_LFSR = 64'h0123_4567_89AB_CDEF
) (
    input  logic        okClk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        reset_pattern,
    input  logic [31:0] pattern,
    input  logic [31:0] length,
    input  logic        fifo_full,
    output logic [63:0] fifo_din,
    output logic        fifo_wr_en,
    output logic        busy,
    output logic        done,
    output logic [31:0] words_sent
);

    state_e      state;
    pat_e        pat_q;
    logic [31:0] len_q;
    logic [63:0] gen;
    logic [63:0] gen_nxt;
    logic [63:0] gen_seed;
    logic        last_wr;
    logic        unused_pattern;

    assign unused_pattern = ^pattern[31:2];

    pattern_step64 #(
        .SEED_LFSR (SEED_LFSR)
    ) u_step (
        .pat  (pat_q),
        .cur  (gen),
        .nxt  (gen_nxt),
        .seed (gen_seed)
    );

    // Reset is folded in so no strobe escapes in the cycle reset is applied.
    assign fifo_wr_en = busy & ~fifo_full & ~stop & ~reset;

    assign last_wr = fifo_wr_en
                   & (len_q != 32'd0)
                   & (words_sent == len_q - 32'd1);

`ifdef PATGEN_SWAP_HALVES_EN
    assign fifo_din = {gen[31:0], gen[63:32]};
`else
    assign fifo_din = gen;
`endif

    always_ff @(posedge okClk) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pat_q      <= PAT_COUNT;
            len_q      <= 32'd0;
            words_sent <= 32'd0;
            gen        <= COUNT_SEED;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (fifo_wr_en) begin
                        gen <= gen_nxt;
                        if (words_sent != WORDS_MAX)
                            words_sent <= words_sent + 32'd1;
                    end
                    if (stop || last_wr) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    if (reset_pattern)
                        gen <= gen_seed;
                    if (start) begin
                        state      <= ST_RUN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pat_q      <= pat_e'(pattern[1:0]);
                        len_q      <= length;
                        words_sent <= 32'd0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_source_64.sv
// Randomized self-checking bench for pattern_source_64.
// Expected words come from a per-pattern reference model kept in the bench.
module tb_pattern_source_64;

    logic        okClk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        reset_pattern;
    logic [31:0] pattern;
    logic [31:0] length;
    logic        fifo_full;
    logic [63:0] fifo_din;
    logic        fifo_wr_en;
    logic        busy;
    logic        done;
    logic [31:0] words_sent;

    int n_cmp;
    int n_bad;

    logic [63:0] m_gen;
    logic [1:0]  m_pat;

    pattern_source_64 dut (
        .okClk         (okClk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .reset_pattern (reset_pattern),
        .pattern       (pattern),
        .length        (length),
        .fifo_full     (fifo_full),
        .fifo_din      (fifo_din),
        .fifo_wr_en    (fifo_wr_en),
        .busy          (busy),
        .done          (done),
        .words_sent    (words_sent)
    );

    initial okClk = 1'b0;
    always #5 okClk = ~okClk;

    function automatic logic [63:0] seed_of(input logic [1:0] p);
        case (p)
            2'd0:    return 64'h0;
            2'd1:    return 64'h1;
            2'd2:    return 64'h0123_4567_89AB_CDEF;
            default: return 64'hAAAA_AAAA_AAAA_AAAA;
        endcase
    endfunction

    function automatic logic [63:0] step_of(input logic [1:0] p,
                                            input logic [63:0] x);
        logic fb;
        case (p)
            2'd0:    return x + 64'd1;
            2'd1:    return (x << 1) | (x >> 63);
            2'd2: begin
                fb = x[63] ^ x[62] ^ x[60] ^ x[59];
                return (x << 1) | {63'd0, fb};
            end
            default: return x ^ 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [63:0] out_of(input logic [63:0] g);
`ifdef PATGEN_SWAP_HALVES_EN
        return {g[31:0], g[63:32]};
`else
        return g;
`endif
    endfunction

    task automatic cyc();
        @(posedge okClk);
        #1;
    endtask

    // Latch pattern p via a start that is stopped at once, then reseed.
    task automatic prime(input logic [1:0] p);
        pattern = {30'd0, p};
        length  = 32'd0;
        start   = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b1;
        cyc();
        stop          = 1'b0;
        reset_pattern = 1'b1;
        cyc();
        reset_pattern = 1'b0;
        m_pat = p;
        m_gen = seed_of(p);
    endtask

    task automatic launch(input logic [1:0] p, input logic [31:0] len);
        pattern = {30'd0, p};
        length  = len;
        start   = 1'b1;
        m_pat   = p;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        @(negedge okClk);
        n_cmp++;
        if ({fifo_wr_en, busy, done} !== 3'b000 || words_sent !== 32'd0
            || fifo_din !== 64'd0) begin
            n_bad++;
            $display("FAIL reset: wr=%b busy=%b done=%b ws=%0d din=%h want 0s",
                     fifo_wr_en, busy, done, words_sent, fifo_din);
        end
        cyc();
        reset = 1'b0;
        cyc();
        m_pat = 2'd0;
        m_gen = 64'd0;
    endtask

    task automatic test_count4();
        prime(2'd0);
        launch(2'd0, 32'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge okClk);
            n_cmp++;
            if (fifo_wr_en !== 1'b1 || busy !== 1'b1
                || fifo_din !== out_of(64'(i))) begin
                n_bad++;
                $display("FAIL count4[%0d]: wr=%b busy=%b din=%h want %h",
                         i, fifo_wr_en, busy, fifo_din, out_of(64'(i)));
            end
            m_gen = step_of(m_pat, m_gen);
            cyc();
        end
        @(negedge okClk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || words_sent !== 32'd4
            || fifo_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL count4_done: done=%b busy=%b ws=%0d wr=%b want 1 0 4 0",
                     done, busy, words_sent, fifo_wr_en);
        end
    endtask

    task automatic test_lfsr();
        logic [63:0] want [2];
        want[0] = 64'h0123_4567_89AB_CDEF;
        want[1] = 64'h0246_8ACF_1357_9BDE;
        prime(2'd2);
        launch(2'd2, 32'd2);
        for (int i = 0; i < 2; i++) begin
            @(negedge okClk);
            n_cmp++;
            if (fifo_wr_en !== 1'b1 || fifo_din !== out_of(want[i])
                || want[i] !== m_gen) begin
                n_bad++;
                $display("FAIL lfsr[%0d]: wr=%b din=%h want %h", i,
                         fifo_wr_en, fifo_din, out_of(want[i]));
            end
            m_gen = step_of(m_pat, m_gen);
            cyc();
        end
        @(negedge okClk);
        n_cmp++;
        if (done !== 1'b1 || words_sent !== 32'd2) begin
            n_bad++;
            $display("FAIL lfsr_done: done=%b ws=%0d want 1 2", done, words_sent);
        end
    endtask

    task automatic test_walk1_backpressure();
        int cnt;
        int hold;
        logic exp_wr;
        prime(2'd1);
        launch(2'd1, 32'd0);
        cnt  = 0;
        hold = 0;
        for (int c = 0; c < 60; c++) begin
            if (cnt >= 2 && hold < 3) begin
                fifo_full = 1'b1;
                hold++;
            end else begin
                fifo_full = (c > 20) ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
            exp_wr = ~fifo_full;
            @(negedge okClk);
            n_cmp++;
            if (fifo_wr_en !== exp_wr) begin
                n_bad++;
                $display("FAIL walk1_wr[%0d]: wr=%b want %b", c, fifo_wr_en, exp_wr);
            end
            if (fifo_wr_en) begin
                n_cmp++;
                if (fifo_din !== out_of(m_gen)) begin
                    n_bad++;
                    $display("FAIL walk1_word[%0d]: din=%h want %h", cnt,
                             fifo_din, out_of(m_gen));
                end
                if (cnt == 2) begin
                    n_cmp++;
                    if (fifo_din !== out_of(64'h4) || hold != 3) begin
                        n_bad++;
                        $display("FAIL walk1_third: din=%h hold=%0d want %h 3",
                                 fifo_din, hold, out_of(64'h4));
                    end
                end
                m_gen = step_of(m_pat, m_gen);
                cnt++;
            end
            cyc();
        end
        fifo_full = 1'b0;
        stop      = 1'b1;
        @(negedge okClk);
        n_cmp++;
        if (fifo_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL walk1_stop_wr: wr=%b want 0", fifo_wr_en);
        end
        cyc();
        stop = 1'b0;
        @(negedge okClk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || words_sent !== 32'(cnt)) begin
            n_bad++;
            $display("FAIL walk1_done: done=%b busy=%b ws=%0d want 1 0 %0d",
                     done, busy, words_sent, cnt);
        end
    endtask

    task automatic test_alt_continue();
        logic [63:0] first_want [3];
        first_want[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        first_want[1] = 64'h5555_5555_5555_5555;
        first_want[2] = 64'hAAAA_AAAA_AAAA_AAAA;
        prime(2'd3);
        for (int r = 0; r < 3; r++) begin
            if (r == 2) begin
                reset_pattern = 1'b1;
                cyc();
                reset_pattern = 1'b0;
                m_gen = seed_of(2'd3);
            end
            launch(2'd3, 32'd3);
            for (int i = 0; i < 3; i++) begin
                @(negedge okClk);
                n_cmp++;
                if (fifo_wr_en !== 1'b1 || fifo_din !== out_of(m_gen)) begin
                    n_bad++;
                    $display("FAIL alt[%0d][%0d]: wr=%b din=%h want %h", r, i,
                             fifo_wr_en, fifo_din, out_of(m_gen));
                end
                if (i == 0 && r > 0) begin
                    n_cmp++;
                    if (fifo_din !== out_of(first_want[r])) begin
                        n_bad++;
                        $display("FAIL alt_first[%0d]: din=%h want %h", r,
                                 fifo_din, out_of(first_want[r]));
                    end
                end
                m_gen = step_of(m_pat, m_gen);
                cyc();
            end
            @(negedge okClk);
            n_cmp++;
            if (done !== 1'b1 || words_sent !== 32'd3) begin
                n_bad++;
                $display("FAIL alt_done[%0d]: done=%b ws=%0d want 1 3", r,
                         done, words_sent);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  p;
        logic [31:0] len;
        int          cnt;
        int          budget;
        logic        exp_wr;
        for (int r = 0; r < 8; r++) begin
            p   = 2'($urandom_range(0, 3));
            len = 32'($urandom_range(1, 20));
            prime(p);
            launch(p, len);
            cnt    = 0;
            budget = 200;
            while (cnt < int'(len) && budget > 0) begin
                fifo_full = ($urandom_range(0, 3) == 0);
                start     = ($urandom_range(0, 7) == 0);
                pattern   = $urandom;
                length    = $urandom;
                exp_wr    = ~fifo_full;
                @(negedge okClk);
                n_cmp++;
                if (fifo_wr_en !== exp_wr || words_sent !== 32'(cnt)) begin
                    n_bad++;
                    $display("FAIL rand_ctl[%0d]: wr=%b ws=%0d want %b %0d", r,
                             fifo_wr_en, words_sent, exp_wr, cnt);
                end
                if (fifo_wr_en) begin
                    n_cmp++;
                    if (fifo_din !== out_of(m_gen)) begin
                        n_bad++;
                        $display("FAIL rand_word[%0d]: pat=%0d din=%h want %h",
                                 r, p, fifo_din, out_of(m_gen));
                    end
                    m_gen = step_of(m_pat, m_gen);
                    cnt++;
                end
                cyc();
                budget--;
            end
            start     = 1'b0;
            fifo_full = 1'b0;
            @(negedge okClk);
            n_cmp++;
            if (budget == 0 || done !== 1'b1 || busy !== 1'b0
                || words_sent !== len) begin
                n_bad++;
                $display("FAIL rand_done[%0d]: done=%b ws=%0d want 1 %0d budget=%0d",
                         r, done, words_sent, len, budget);
            end
        end
    endtask

    task automatic test_stop_start();
        prime(2'd0);
        launch(2'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            m_gen = step_of(m_pat, m_gen);
            cyc();
        end
        stop  = 1'b1;
        start = 1'b1;
        @(negedge okClk);
        n_cmp++;
        if (fifo_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL stopstart_wr: wr=%b want 0", fifo_wr_en);
        end
        cyc();
        stop  = 1'b0;
        start = 1'b0;
        @(negedge okClk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || words_sent !== 32'd3
            || fifo_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL stopstart_done: done=%b busy=%b ws=%0d wr=%b want 1 0 3 0",
                     done, busy, words_sent, fifo_wr_en);
        end
    endtask

    task automatic test_reset_midrun();
        int cnt;
        prime(2'd0);
        launch(2'd0, 32'd100);
        cnt = 0;
        while (cnt < 50) begin
            @(negedge okClk);
            n_cmp++;
            if (fifo_wr_en !== 1'b1 || fifo_din !== out_of(m_gen)) begin
                n_bad++;
                $display("FAIL midrun_word[%0d]: wr=%b din=%h want %h", cnt,
                         fifo_wr_en, fifo_din, out_of(m_gen));
            end
            m_gen = step_of(m_pat, m_gen);
            cnt++;
            cyc();
        end
        reset = 1'b1;
        @(negedge okClk);
        n_cmp++;
        if (fifo_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_reset_wr: wr=%b want 0", fifo_wr_en);
        end
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge okClk);
            n_cmp++;
            if ({fifo_wr_en, busy, done} !== 3'b000 || words_sent !== 32'd0
                || fifo_din !== 64'd0) begin
                n_bad++;
                $display("FAIL midrun_after[%0d]: wr=%b busy=%b done=%b ws=%0d din=%h",
                         i, fifo_wr_en, busy, done, words_sent, fifo_din);
            end
            cyc();
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        reset         = 1'b1;
        start         = 1'b0;
        stop          = 1'b0;
        reset_pattern = 1'b0;
        pattern       = 32'd0;
        length        = 32'd0;
        fifo_full     = 1'b0;
        m_gen         = 64'd0;
        m_pat         = 2'd0;
        test_reset();
        test_count4();
        test_lfsr();
        test_walk1_backpressure();
        test_alt_continue();
        test_random();
        test_stop_start();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
